// File: rtl/sar_pkg.sv
// Shared constants for the successive-approximation search engine:
// FSM state encodings and the step-counter width helper.
package sar_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // A search takes at most n compares, so the counter must hold 0..n.
    function automatic int steps_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sar_search_cmp.sv
// Parameterised unsigned magnitude comparator, purely combinational.
module sar_search_cmp #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         A_gt_B,
    output logic         A_eq_B,
    output logic         A_lt_B
);

    assign A_gt_B = (A > B);
    assign A_eq_B = (A == B);
    assign A_lt_B = (A < B);

endmodule

// File: rtl/sar_search.sv
// Binary search for a latched target, one magnitude compare per cycle.
// The comparator's gt/eq flags decide each trial bit, MSB first.
module sar_search
    import sar_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = steps_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  target,
    output logic [N-1:0]  trial,
    output logic [N-1:0]  result,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] steps
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] FIRST_TRIAL = N'(1) << (N - 1);
    localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

    logic [1:0]    state;
    logic [N-1:0]  tgt_q;
    logic [IW-1:0] idx;
    logic          cmp_gt;
    logic          cmp_eq;
    logic          cmp_lt_unused;
    logic [N-1:0]  cleared;
    logic [N-1:0]  advanced;

    sar_search_cmp #(.N(N)) u_cmp (
        .A      (trial),
        .B      (tgt_q),
        .A_gt_B (cmp_gt),
        .A_eq_B (cmp_eq),
        .A_lt_B (cmp_lt_unused)
    );

    // Resolve the bit under test, then tentatively set the next lower bit.
    always_comb begin
        cleared = trial;
        if (cmp_gt) begin
            cleared[idx] = 1'b0;
        end
        advanced = cleared;
        if (idx != '0) begin
            advanced[idx - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            tgt_q  <= '0;
            trial  <= '0;
            result <= '0;
            steps  <= '0;
            idx    <= TOP_IDX;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt_q <= target;
                        trial <= FIRST_TRIAL;
                        idx   <= TOP_IDX;
                        steps <= '0;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    steps <= steps + SW'(1);
                    if (cmp_eq) begin
                        result <= trial;
                        state  <= DONE;
                    end else if (idx == '0) begin
                        trial  <= cleared;
                        result <= cleared;
                        state  <= DONE;
                    end else begin
                        trial <= advanced;
                        idx   <= idx - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == SEARCH);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed cases, reset abort, exhaustive
// sweep and random targets, compared against an arithmetic bit-by-bit search model.
module tb_sar_search;

    localparam int N  = 4;
    localparam int SW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  target;
    logic [N-1:0]  trial;
    logic [N-1:0]  result;
    logic          busy;
    logic          done;
    logic [SW-1:0] steps;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_trials[$];
    int exp_steps;
    int exp_result;

    always #5 clk = ~clk;

    sar_search #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .trial  (trial),
        .result (result),
        .busy   (busy),
        .done   (done),
        .steps  (steps)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Build the answer MSB first: try acc + 2^b, keep it if it does not overshoot.
    task automatic build_model(input int tgt);
        int acc;
        int t;
        acc = 0;
        exp_trials.delete();
        exp_result = 0;
        for (int b = N - 1; b >= 0; b--) begin
            t = acc + (1 << b);
            exp_trials.push_back(t);
            if (t == tgt) begin
                exp_result = t;
                break;
            end
            if (t < tgt) acc = t;
            if (b == 0) exp_result = acc;
        end
        exp_steps = exp_trials.size();
    endtask

    task automatic applyStimulus(input int tgt, input bit disturb, input int alt);
        build_model(tgt);
        start  = 1'b1;
        target = N'(tgt);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput($sformatf("busy_start_t%0d", tgt), 32'(busy), 1);
        for (int k = 0; k < exp_steps; k++) begin
            checkOutput($sformatf("trial_t%0d_k%0d", tgt, k), 32'(trial), exp_trials[k]);
            checkOutput($sformatf("steps_t%0d_k%0d", tgt, k), 32'(steps), k);
            checkOutput($sformatf("done_early_t%0d_k%0d", tgt, k), 32'(done), 0);
            if (disturb) begin
                target = N'(alt);
                start  = (k == 0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checkOutput($sformatf("done_t%0d", tgt), 32'(done), 1);
        checkOutput($sformatf("busy_end_t%0d", tgt), 32'(busy), 0);
        checkOutput($sformatf("result_model_t%0d", tgt), 32'(result), exp_result);
        checkOutput($sformatf("result_target_t%0d", tgt), 32'(result), tgt);
        checkOutput($sformatf("steps_final_t%0d", tgt), 32'(steps), exp_steps);
        @(posedge clk); #1;
        checkOutput($sformatf("done_width_t%0d", tgt), 32'(done), 0);
        checkOutput($sformatf("busy_idle_t%0d", tgt), 32'(busy), 0);
        checkOutput($sformatf("result_hold_t%0d", tgt), 32'(result), tgt);
        checkOutput($sformatf("steps_hold_t%0d", tgt), 32'(steps), exp_steps);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        target = '0;
        #2;
        checkOutput("reset_trial", 32'(trial), 0);
        checkOutput("reset_result", 32'(result), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_steps", 32'(steps), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases, including early exit and both extremes.
        applyStimulus(5, 1'b0, 0);
        applyStimulus(8, 1'b0, 0);
        applyStimulus(0, 1'b0, 0);
        applyStimulus(15, 1'b0, 0);
        applyStimulus(4, 1'b1, 9);

        // Abort in the second search cycle after a run that left result nonzero.
        applyStimulus(5, 1'b0, 0);
        start  = 1'b1;
        target = N'(7);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_trial", 32'(trial), 0);
        checkOutput("abort_result", 32'(result), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        checkOutput("abort_steps", 32'(steps), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("abort_no_done_c%0d", c), 32'(done), 0);
            checkOutput($sformatf("abort_no_busy_c%0d", c), 32'(busy), 0);
            @(posedge clk); #1;
        end
        applyStimulus(3, 1'b0, 0);

        // Back-to-back sweep over every target.
        for (int t = 0; t < (1 << N); t++) begin
            applyStimulus(t, 1'b0, 0);
        end

        // Random targets with random mid-search target changes and re-starts.
        for (int r = 0; r < 24; r++) begin
            applyStimulus(int'($urandom_range(0, (1 << N) - 1)),
                          bit'($urandom_range(0, 1)),
                          int'($urandom_range(0, (1 << N) - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
